// File: rtl/display_scanner.sv
// display_scanner
//   Multiplexed 7-segment driver. Scans N_DIG digits, advancing one digit per
//   i_Tick strobe, with DEAD blanking cycles after every digit switch. The hex
//   value is double-buffered (pend -> cur), and the commit happens only when
//   the scan wraps back to digit 0, so a frame never mixes old and new data.
//
//   Optional feature: define DISPLAY_LZB_EN for leading-zero blanking. Digits
//   above the most significant nonzero nibble of cur show no segments, but
//   their DP is still shown. Digit 0 is never blanked, and scan timing does
//   not change.
//
// Parameters
//   N_DIG        digits scanned (2..8)
//   DEAD         blanking cycles after each digit switch (1..15)
//   SEG_ACT_LOW  1 = segment/DP pins active-low
//   DIG_ACT_LOW  1 = anode enable pins active-low
// Ports
//   i_Clk    system clock (rising edge)
//   i_Reset  synchronous active-high reset
//   i_Tick   one-cycle advance strobe
//   i_Load   capture i_Data/i_DP into the pending buffer
//   i_Data   hex nibbles, digit 0 = [3:0]
//   i_DP     decimal point per digit
//   o_Seg    segments a..g (bit0 = a), registered
//   o_DP     decimal point of the active digit, registered
//   o_An     one-hot digit enable, registered
//   o_Frame  one-cycle pulse when the scan wraps to digit 0, registered
module display_scanner #(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned DEAD        = 2,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Tick,
  input  logic               i_Load,
  input  logic [4*N_DIG-1:0] i_Data,
  input  logic [N_DIG-1:0]   i_DP,
  output logic [6:0]         o_Seg,
  output logic               o_DP,
  output logic [N_DIG-1:0]   o_An,
  output logic               o_Frame
);

  localparam int unsigned IW = $clog2(N_DIG);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [IW-1:0]    IDX_LAST = IW'(N_DIG - 1);
  localparam logic [3:0]       DEAD_LD  = 4'(DEAD);
  localparam logic [6:0]       SEG_OFF  = {7{SEG_ACT_LOW}};
  localparam logic [N_DIG-1:0] AN_OFF   = {N_DIG{DIG_ACT_LOW}};

  typedef struct packed {
    logic [N_DIG-1:0][3:0] nib;
    logic [N_DIG-1:0]      dp;
  } disp_t;

  // Active-high patterns; polarity is applied only at the output register.
  function automatic logic [6:0] seg_dec(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [1:0]    state, st_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [3:0]    cnt, cnt_n;
  disp_t         cur, cur_n, pend, in_f;
  logic          pend_v, pend_v_n;
  logic          wrap, frame_n, blank_n;
  logic [N_DIG-1:0] onehot;

  assign in_f.nib = i_Data;
  assign in_f.dp  = i_DP;
  assign idx_inc  = (idx == IDX_LAST) ? '0 : idx + IW'(1);

  // Next-state logic. Outputs are registered from these next values so the
  // pins change on the same edge the FSM does.
  always_comb begin
    st_n  = state;
    idx_n = idx;
    cnt_n = cnt;
    wrap  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Tick) begin
          st_n  = S_DEAD;
          idx_n = '0;
          cnt_n = DEAD_LD;
        end
      end
      S_DEAD: begin
        // A tick while blanking still advances, and blanking restarts so
        // the new digit also gets its full dead time.
        if (i_Tick) begin
          idx_n = idx_inc;
          cnt_n = DEAD_LD;
          wrap  = (idx == IDX_LAST);
        end else if (cnt == 4'd1) begin
          st_n = S_DRIVE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_DRIVE: begin
        if (i_Tick) begin
          st_n  = S_DEAD;
          idx_n = idx_inc;
          cnt_n = DEAD_LD;
          wrap  = (idx == IDX_LAST);
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  // Leaving IDLE also starts a frame at digit 0, but only a real wrap from
  // the last digit commits the pending buffer.
  assign frame_n = wrap | ((state == S_IDLE) & i_Tick);

  // A load on the wrap edge bypasses pend and lands directly in cur.
  always_comb begin
    cur_n    = cur;
    pend_v_n = pend_v;
    if (wrap) begin
      pend_v_n = 1'b0;
      if (i_Load)      cur_n = in_f;
      else if (pend_v) cur_n = pend;
    end else if (i_Load) begin
      pend_v_n = 1'b1;
    end
  end

`ifdef DISPLAY_LZB_EN
  // lz[k] = every nibble from digit k upward is zero.
  logic [N_DIG:0] lz;
  assign lz[N_DIG] = 1'b1;
  for (genvar k = 0; k < N_DIG; k++) begin : g_lz
    assign lz[k] = lz[k+1] & (cur_n.nib[k] == 4'h0);
  end
  assign blank_n = (idx_n != '0) & lz[idx_n];
`else
  assign blank_n = 1'b0;
`endif

  assign onehot = N_DIG'(1) << idx_n;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      cur     <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      o_Seg   <= SEG_OFF;
      o_DP    <= SEG_ACT_LOW;
      o_An    <= AN_OFF;
      o_Frame <= 1'b0;
    end else begin
      state   <= st_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      cur     <= cur_n;
      pend_v  <= pend_v_n;
      o_Frame <= frame_n;
      if (i_Load && !wrap) pend <= in_f;
      if (st_n == S_DRIVE) begin
        o_An  <= AN_OFF ^ onehot;
        o_Seg <= (blank_n ? 7'h00 : seg_dec(cur_n.nib[idx_n])) ^ SEG_OFF;
        o_DP  <= cur_n.dp[idx_n] ^ SEG_ACT_LOW;
      end else begin
        o_An  <= AN_OFF;
        o_Seg <= SEG_OFF;
        o_DP  <= SEG_ACT_LOW;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Tick, i_Load;
  logic [15:0] i_Data;
  logic [3:0]  i_DP;
  logic [6:0]  o_Seg;
  logic        o_DP;
  logic [3:0]  o_An;
  logic        o_Frame;

  int checks = 0;
  int fails  = 0;

  // Inverted (active-low) patterns for the values used below.
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, SB = 7'h03, SE = 7'h06,
                         SF = 7'h0E, OFF = 7'h7F;
`ifdef DISPLAY_LZB_EN
  localparam logic [6:0] ZS = 7'h7F;  // zero digit above the leading nonzero
`else
  localparam logic [6:0] ZS = 7'h40;
`endif

  display_scanner #(.N_DIG(4), .DEAD(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Tick(i_Tick), .i_Load(i_Load),
    .i_Data(i_Data), .i_DP(i_DP), .o_Seg(o_Seg), .o_DP(o_DP), .o_An(o_An),
    .o_Frame(o_Frame)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic        tick, load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo, fr;
  } vec_t;

  vec_t tv[$];

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'd1;
    return 4'hF ^ (one << d);
  endfunction

  task automatic add(input logic t, l, input logic [15:0] d, input logic [3:0] p,
                     input logic [3:0] an, input logic [6:0] seg, input logic dpo, fr);
    vec_t v;
    v.tick = t; v.load = l; v.data = d; v.dp = p;
    v.an = an; v.seg = seg; v.dpo = dpo; v.fr = fr;
    tv.push_back(v);
  endtask

  // Tick row (with optional load) followed by the second blank row.
  task automatic tk(input logic fr, input logic l, input logic [15:0] d, input logic [3:0] p);
    add(1'b1, l, d, p, 4'hF, OFF, 1'b1, fr);
    add(1'b0, 1'b0, 16'h0, 4'h0, 4'hF, OFF, 1'b1, 1'b0);
  endtask

  task automatic dr(input int dg, input logic [6:0] seg, input logic dpo);
    add(1'b0, 1'b0, 16'h0, 4'h0, an_of(dg), seg, dpo, 1'b0);
    add(1'b0, 1'b0, 16'h0, 4'h0, an_of(dg), seg, dpo, 1'b0);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step(input logic t, l, input logic [15:0] d, input logic [3:0] p);
    i_Tick = t; i_Load = l; i_Data = d; i_DP = p;
    @(negedge i_Clk);
    i_Tick = 1'b0; i_Load = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [3:0] an, input logic [6:0] seg,
                     input logic dp, input logic fr);
    checks++;
    if (o_An !== an || o_Seg !== seg || o_DP !== dp || o_Frame !== fr) begin
      fails++;
      $display("FAIL %s: got an=%h seg=%h dp=%b frame=%b, want an=%h seg=%h dp=%b frame=%b",
               nm, o_An, o_Seg, o_DP, o_Frame, an, seg, dp, fr);
    end
  endtask

  task automatic chk_an(input string nm, input logic [3:0] an, input logic fr);
    checks++;
    if (o_An !== an || o_Frame !== fr) begin
      fails++;
      $display("FAIL %s: got an=%h frame=%b, want an=%h frame=%b", nm, o_An, o_Frame, an, fr);
    end
  endtask

  // One digit slot: tick, two blank cycles, two drive cycles.
  task automatic dig(input string nm, input int d, input logic [6:0] seg, input logic dpo,
                     input logic fr);
    step(1'b1, 1'b0, 16'h0, 4'h0); chk({nm, "_b1"}, 4'hF, OFF, 1'b1, fr);
    step(1'b0, 1'b0, 16'h0, 4'h0); chk({nm, "_b2"}, 4'hF, OFF, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0); chk({nm, "_d1"}, an_of(d), seg, dpo, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0); chk({nm, "_d2"}, an_of(d), seg, dpo, 1'b0);
  endtask

  initial begin
    i_Reset = 1'b1; i_Tick = 1'b0; i_Load = 1'b0; i_Data = 16'h0; i_DP = 4'h0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    chk("reset", 4'hF, OFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0);
      chk($sformatf("idle%0d", i), 4'hF, OFF, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 16'h1234, 4'h0);
    chk("load_idle", 4'hF, OFF, 1'b1, 1'b0);

    // First frame after reset: anode order and frame pulse only.
    for (int d = 0; d < 4; d++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0); chk_an($sformatf("f1_t%0d", d), 4'hF, d == 0);
      step(1'b0, 1'b0, 16'h0, 4'h0); chk_an($sformatf("f1_b%0d", d), 4'hF, 1'b0);
      step(1'b0, 1'b0, 16'h0, 4'h0); chk_an($sformatf("f1_d%0d", d), an_of(d), 1'b0);
      step(1'b0, 1'b0, 16'h0, 4'h0); chk_an($sformatf("f1_e%0d", d), an_of(d), 1'b0);
    end

    // Frame 2: 0x1234 committed at the wrap.
    tk(1'b1, 1'b0, 16'h0, 4'h0); dr(0, S4, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(1, S3, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(2, S2, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(3, S1, 1'b1);
    // Frame 3: 0xAAAA then 0xBEEF loaded mid-frame; old value keeps showing.
    tk(1'b1, 1'b0, 16'h0, 4'h0);
    add(1'b0, 1'b1, 16'hAAAA, 4'h0, an_of(0), S4, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0,    4'h0, an_of(0), S4, 1'b1, 1'b0);
    tk(1'b0, 1'b0, 16'h0, 4'h0);
    add(1'b0, 1'b1, 16'hBEEF, 4'h0, an_of(1), S3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0,    4'h0, an_of(1), S3, 1'b1, 1'b0);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(2, S2, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(3, S1, 1'b1);
    // Frame 4: 0xBEEF, last load wins.
    tk(1'b1, 1'b0, 16'h0, 4'h0); dr(0, SF, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(1, SE, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(2, SE, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0); dr(3, SB, 1'b1);
    // Frame 5: load 0x00F0 (DP on digit 0) on the wrap tick itself.
    tk(1'b1, 1'b1, 16'h00F0, 4'h1); dr(0, S0, 1'b0);
    tk(1'b0, 1'b0, 16'h0, 4'h0);    dr(1, SF, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0);    dr(2, ZS, 1'b1);
    tk(1'b0, 1'b0, 16'h0, 4'h0);    dr(3, ZS, 1'b1);
    // Frame 6: nothing pending, so digit 0 still shows 0 with DP.
    tk(1'b1, 1'b0, 16'h0, 4'h0);    dr(0, S0, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].tick, tv[i].load, tv[i].data, tv[i].dp);
      chk($sformatf("vec%0d", i), tv[i].an, tv[i].seg, tv[i].dpo, tv[i].fr);
    end

    // Tick every cycle: stays blank, frame pulses on each wrap.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      chk($sformatf("fast%0d", i), 4'hF, OFF, 1'b1, (i == 3) || (i == 7));
    end
    step(1'b0, 1'b0, 16'h0, 4'h0); chk("fast_b", 4'hF, OFF, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0); chk("fast_d", an_of(0), S0, 1'b0, 1'b0);

    // Reset during the dead time of digit 2, with a pending load outstanding.
    dig("pre1", 1, SF, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h9999, 4'hF); chk("pend9", an_of(1), SF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);    chk("dead2", 4'hF, OFF, 1'b1, 1'b0);
    i_Reset = 1'b1;
    step(1'b0, 1'b0, 16'h0, 4'h0);    chk("rst_mid", 4'hF, OFF, 1'b1, 1'b0);
    i_Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0);
      chk($sformatf("rst_idle%0d", i), 4'hF, OFF, 1'b1, 1'b0);
    end
    dig("r0", 0, S0, 1'b1, 1'b1);
    dig("r1", 1, ZS, 1'b1, 1'b0);
    dig("r2", 2, ZS, 1'b1, 1'b0);
    dig("r3", 3, ZS, 1'b1, 1'b0);
    dig("r4", 0, S0, 1'b1, 1'b1);

    // 0x0050 with DP on digit 3.
    step(1'b0, 1'b1, 16'h0050, 4'h8); chk("ld50", an_of(0), S0, 1'b1, 1'b0);
    dig("z1", 1, ZS, 1'b1, 1'b0);
    dig("z2", 2, ZS, 1'b1, 1'b0);
    dig("z3", 3, ZS, 1'b1, 1'b0);
    dig("l0", 0, S0, 1'b1, 1'b1);
    dig("l1", 1, S5, 1'b1, 1'b0);
    dig("l2", 2, ZS, 1'b1, 1'b0);
    dig("l3", 3, ZS, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
